// File: rtl/reg_read_arbiter_pkg.sv
// Shared definitions for the register read arbiter: FSM encodings, sizes and a
// small index-to-one-hot helper used by both the arbiter and its picker.
package reg_read_arbiter_pkg;

    // Number of requesters sharing the register-select mux.
    localparam int unsigned NReq = 4;
    // Width of a register index on the 16:1 mux select.
    localparam int unsigned IdxW = 4;
    // Width of a requester index / round-robin pointer.
    localparam int unsigned PtrW = 2;

    // Fixed encodings; other blocks decode these values directly.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StSel  = 2'b01,
        StDone = 2'b10
    } state_e;

    // Expand a requester index into a one-hot requester vector.
    function automatic logic [NReq-1:0] onehot_req(input logic [PtrW-1:0] idx);
        logic [NReq-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/reg_read_arbiter_rr_pick.sv
// Round-robin picker: scans requests upward from the pointer (mod NReq) and
// reports the first asserted request. Purely combinational.
module rr_pick
    import reg_read_arbiter_pkg::*;
(
    input  logic [NReq-1:0] req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic            found_o,
    output logic [PtrW-1:0] winner_o
);

    logic [PtrW-1:0] idx;

    // First set request at or after the pointer wins; index wraps naturally in PtrW bits.
    always_comb begin
        found_o  = 1'b0;
        winner_o = ptr_i;
        idx      = '0;
        for (int unsigned off = 0; off < NReq; off++) begin
            idx = ptr_i + PtrW'(off);
            if (!found_o && req_i[idx]) begin
                found_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/reg_read_arbiter.sv
// Arbitrates four requesters onto one shared 16:1 register-select mux.
// Each read takes IDLE -> SEL -> DONE: the winner's index drives the mux during
// SEL, the mux output is captured at the end of SEL and presented in DONE.
module reg_read_arbiter
    import reg_read_arbiter_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NReq-1:0]  req_i,
    input  logic [IdxW-1:0]  addr0_i,
    input  logic [IdxW-1:0]  addr1_i,
    input  logic [IdxW-1:0]  addr2_i,
    input  logic [IdxW-1:0]  addr3_i,
    output logic [IdxW-1:0]  selecm_o,
    input  logic [N-1:0]     q_i,
    output logic [NReq-1:0]  gnt_o,
    output logic [N-1:0]     rd_data_o,
    output logic [NReq-1:0]  rd_valid_o,
    output logic             busy_o
);

    state_e          state_q;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] winner_q;
    logic [IdxW-1:0] addr_q, addr_d;
    logic [N-1:0]    rd_data_q;
    logic [NReq-1:0] rd_valid_q;

    logic            pick_found;
    logic [PtrW-1:0] pick_winner;

    rr_pick u_rr_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .found_o  (pick_found),
        .winner_o (pick_winner)
    );

    // Candidate index and pointer for the requester the picker has chosen.
    always_comb begin
        ptr_d = pick_winner + PtrW'(1);
        unique case (pick_winner)
            2'd0:    addr_d = addr0_i;
            2'd1:    addr_d = addr1_i;
            2'd2:    addr_d = addr2_i;
            default: addr_d = addr3_i;
        endcase
    end

    // Read sequencer: latch winner in IDLE, capture mux data in SEL, pulse valid in DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            winner_q   <= '0;
            addr_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            rd_valid_q <= '0;
            case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        winner_q <= pick_winner;
                        addr_q   <= addr_d;
                        ptr_q    <= ptr_d;
                        state_q  <= StSel;
                    end
                end
                StSel: begin
                    // Request and address are not re-sampled here; the latched copy wins.
                    rd_data_q  <= q_i;
                    rd_valid_q <= onehot_req(winner_q);
                    state_q    <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Grant and busy are decodes of registered state only.
    always_comb begin
        gnt_o  = (state_q == StSel) ? onehot_req(winner_q) : '0;
        busy_o = (state_q != StIdle);
    end

    assign selecm_o   = addr_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

    a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
    a_rv_onehot0  : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rd_valid_o));
    a_gnt_rv_excl : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     !((|gnt_o) && (|rd_valid_o)));

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Scoreboard bench for reg_read_arbiter: directed tests push expected grants
// and read completions; a negedge monitor pops and compares them.
module tb_reg_read_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  addr0, addr1, addr2, addr3;
    logic [3:0]  selecm;
    logic [15:0] q;
    logic [3:0]  gnt;
    logic [15:0] rd_data;
    logic [3:0]  rd_valid;
    logic        busy;

    typedef struct packed {
        logic [3:0]  rv;
        logic [15:0] data;
        logic [3:0]  sel;
    } exp_t;

    exp_t       exp_rv[$];
    logic [3:0] exp_gnt[$];
    logic [15:0] rf [16];

    int checks = 0;
    int errors = 0;

    reg_read_arbiter #(.N(16)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .addr0_i    (addr0),
        .addr1_i    (addr1),
        .addr2_i    (addr2),
        .addr3_i    (addr3),
        .selecm_o   (selecm),
        .q_i        (q),
        .gnt_o      (gnt),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .busy_o     (busy)
    );

    // Register file behind the shared mux: R_k = 16'h1111*k, except R_7 = A5A5.
    initial begin
        for (int k = 0; k < 16; k++) rf[k] = 16'(16'h1111 * k);
        rf[7] = 16'hA5A5;
    end
    assign q = rf[selecm];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented grant / completion must match the next expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (gnt !== 4'b0000 && gnt !== 4'bxxxx) begin
                if (exp_gnt.size() == 0) check("unexpected_gnt", {28'd0, gnt}, 32'd0);
                else check("gnt_order", {28'd0, gnt}, {28'd0, exp_gnt.pop_front()});
            end
            if (rd_valid !== 4'b0000 && rd_valid !== 4'bxxxx) begin
                if (exp_rv.size() == 0) begin
                    check("unexpected_rd_valid", {28'd0, rd_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_rv.pop_front();
                    check("rd_valid", {28'd0, rd_valid}, {28'd0, e.rv});
                    check("rd_data", {16'd0, rd_data}, {16'd0, e.data});
                    check("selecm_at_valid", {28'd0, selecm}, {28'd0, e.sel});
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_selecm"}, {28'd0, selecm}, 32'd0);
        check({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
        check({tag, "_rd_valid"}, {28'd0, rd_valid}, 32'd0);
        check({tag, "_rd_data"}, {16'd0, rd_data}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        check("pending_exp_at_reset", exp_rv.size() + exp_gnt.size(), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for n completion pulses; optionally require a fixed spacing.
    task automatic wait_valid(input int n, input int gap);
        int seen = 0;
        int last = -1;
        int c = 0;
        while (seen < n && c < 200) begin
            @(negedge clk);
            c++;
            if (rd_valid !== 4'b0000) begin
                if (gap > 0 && last >= 0) check("rv_spacing", c - last, gap);
                last = c;
                seen++;
            end
        end
        if (seen < n) check("rv_timeout", seen, n);
    endtask

    task automatic push(input logic [3:0] g, input logic [15:0] d, input logic [3:0] s);
        exp_t e;
        e.rv = g; e.data = d; e.sel = s;
        exp_gnt.push_back(g);
        exp_rv.push_back(e);
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 4'b0000;
        addr0 = 4'd0; addr1 = 4'd0; addr2 = 4'd0; addr3 = 4'd0;

        // Single request with explicit latency checks.
        do_reset();
        push(4'b0010, 16'hA5A5, 4'd7);
        @(posedge clk); #1;
        addr1 = 4'd7;
        req   = 4'b0010;
        @(posedge clk); #1;
        check("t1_gnt_t+1", {28'd0, gnt}, 32'h2);
        check("t1_selecm_t+1", {28'd0, selecm}, 32'd7);
        check("t1_busy_sel", {31'd0, busy}, 32'd1);
        check("t1_no_valid_in_sel", {28'd0, rd_valid}, 32'd0);
        @(posedge clk); #1;
        check("t1_rd_valid_t+2", {28'd0, rd_valid}, 32'h2);
        check("t1_rd_data_t+2", {16'd0, rd_data}, 32'hA5A5);
        check("t1_gnt_done", {28'd0, gnt}, 32'd0);
        req = 4'b0000;
        @(posedge clk); #1;
        check("t1_busy_idle", {31'd0, busy}, 32'd0);
        check("t1_rd_valid_idle", {28'd0, rd_valid}, 32'd0);
        check("t1_rd_data_hold", {16'd0, rd_data}, 32'hA5A5);
        check("t1_selecm_persist", {28'd0, selecm}, 32'd7);

        // All four requesting continuously: order 0,1,2,3,0 every 3 cycles.
        do_reset();
        addr0 = 4'd0; addr1 = 4'd5; addr2 = 4'd10; addr3 = 4'd15;
        push(4'b0001, 16'h0000, 4'd0);
        push(4'b0010, 16'h5555, 4'd5);
        push(4'b0100, 16'hAAAA, 4'd10);
        push(4'b1000, 16'hFFFF, 4'd15);
        push(4'b0001, 16'h0000, 4'd0);
        req = 4'b1111;
        wait_valid(5, 3);
        req = 4'b0000;

        // Fairness: move ptr to 1 with one read from requester 0, then 3 and 0 alternate.
        do_reset();
        addr0 = 4'd2; addr3 = 4'd9;
        push(4'b0001, 16'h2222, 4'd2);
        push(4'b1000, 16'h9999, 4'd9);
        push(4'b0001, 16'h2222, 4'd2);
        push(4'b1000, 16'h9999, 4'd9);
        push(4'b0001, 16'h2222, 4'd2);
        req = 4'b0001;
        wait_valid(1, 0);
        req = 4'b1001;
        wait_valid(4, 3);
        req = 4'b0000;

        // Requester 2 drops its request during SEL; completion still issued.
        do_reset();
        addr2 = 4'd3;
        push(4'b0100, 16'h3333, 4'd3);
        req = 4'b0100;
        @(posedge clk); #1;
        check("t4_gnt_sel", {28'd0, gnt}, 32'h4);
        req   = 4'b0000;
        addr2 = 4'd9;
        @(posedge clk); #1;
        check("t4_rd_valid", {28'd0, rd_valid}, 32'h4);
        check("t4_rd_data", {16'd0, rd_data}, 32'h3333);
        @(posedge clk); #1;
        check("t4_busy_idle", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("t4_no_regrant", {31'd0, busy}, 32'd0);

        // Reset during SEL aborts the read; afterwards the search starts from ptr 0.
        do_reset();
        addr2 = 4'd12; addr3 = 4'd1;
        req = 4'b0100;
        @(posedge clk); #1;
        check("t5_gnt_before_abort", {28'd0, gnt}, 32'h4);
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        check_all_zero("t5_abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("t5_no_valid_after_abort", {28'd0, rd_valid}, 32'd0);
            check("t5_idle_after_abort", {31'd0, busy}, 32'd0);
        end
        push(4'b0100, 16'hCCCC, 4'd12);
        push(4'b1000, 16'h1111, 4'd1);
        req = 4'b1100;
        wait_valid(1, 0);
        req = 4'b1000;
        wait_valid(1, 0);
        req = 4'b0000;

        // Index boundaries back to back: 15 then 0.
        do_reset();
        addr3 = 4'd15; addr0 = 4'd0;
        push(4'b1000, 16'hFFFF, 4'd15);
        push(4'b0001, 16'h0000, 4'd0);
        req = 4'b1000;
        wait_valid(1, 0);
        req = 4'b0001;
        wait_valid(1, 0);
        req = 4'b0000;
        repeat (4) @(negedge clk);

        check("final_exp_rv_drained", exp_rv.size(), 32'd0);
        check("final_exp_gnt_drained", exp_gnt.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
